// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and stage-1 FSM encoding for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned FLGW = 4;

  localparam logic [OPW-1:0] OP_ADD = 4'h0;
  localparam logic [OPW-1:0] OP_SUB = 4'h1;
  localparam logic [OPW-1:0] OP_ADC = 4'h2;
  localparam logic [OPW-1:0] OP_SBC = 4'h3;
  localparam logic [OPW-1:0] OP_MUL = 4'h4;
  localparam logic [OPW-1:0] OP_AND = 4'h8;
  localparam logic [OPW-1:0] OP_OR  = 4'h9;
  localparam logic [OPW-1:0] OP_XOR = 4'hA;
  localparam logic [OPW-1:0] OP_NOT = 4'hB;
  localparam logic [OPW-1:0] OP_SHR = 4'hC;
  localparam logic [OPW-1:0] OP_SHL = 4'hD;
  localparam logic [OPW-1:0] OP_ROR = 4'hE;
  localparam logic [OPW-1:0] OP_ROL = 4'hF;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // 0101..0111 are unassigned; MUL exists only when the multiplier is built.
  function automatic logic op_legal(input logic [OPW-1:0] op, input logic mul_en);
    case (op)
      OP_MUL:             return mul_en;
      4'h5, 4'h6, 4'h7:   return 1'b0;
      default:            return 1'b1;
    endcase
  endfunction

  function automatic logic op_sets_cf(input logic [OPW-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: W steps after start, holds the low W product bits until acked.
module alu_mul_iter #(
  parameter int unsigned W = 8
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         ack_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] p_o
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  acc_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  assign done_o = busy_q && (cnt_q == '0);
  assign busy_o = busy_q;
  assign p_o    = acc_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= CW'(W);
      busy_q   <= 1'b1;
    end else if (busy_q && (cnt_q != '0)) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end else if (done_o && ack_i) begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage handshaked ALU: operand register (with iterative MUL) feeding a result register with flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic            ck,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  ctr,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    o,
  output logic [FLGW-1:0] flags,
  output logic            err
);

  state_t         state_q, state_d;
  logic           s1_valid_q;
  logic [OPW-1:0] s1_op_q;
  logic [W-1:0]   s1_a_q, s1_b_q;

  logic            out_valid_q, err_q, cf_q;
  logic [W-1:0]    o_q;
  logic [FLGW-1:0] flags_q;

  logic            accept, mul_start, mul_busy, mul_done, s1_cmpl, s1_move;
  logic [W-1:0]    mul_p;
  logic [W-1:0]    res_d;
  logic [FLGW-1:0] flags_d;
  logic            err_d, cf_d, c_d, v_d, cin;
  logic [W:0]      sum_ext, dif_ext;

  // A non-MUL op is always complete; a MUL is complete once the multiplier reports done.
  assign s1_cmpl   = !mul_busy || mul_done;
  assign s1_move   = s1_valid_q && s1_cmpl && (!out_valid_q || out_ready);
  assign in_ready  = (state_q == ST_IDLE) && (!s1_valid_q || s1_move);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (ctr == OP_MUL) && MUL_EN;

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(.W(W)) u_mul (
      .ck      (ck),
      .rst_n   (rst_n),
      .start_i (mul_start),
      .ack_i   (s1_move),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (mul_busy),
      .done_o  (mul_done),
      .p_o     (mul_p)
    );
  end else begin : g_no_mul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_p    = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (s1_move)   state_d = ST_IDLE;
    endcase
  end

  // cf_q already reflects every older op: results are computed as they enter the result register.
  assign cin     = ((s1_op_q == OP_ADC) || (s1_op_q == OP_SBC)) ? cf_q : 1'b0;
  assign sum_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{W{1'b0}}, cin};
  assign dif_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q} - {{W{1'b0}}, cin};

  always_comb begin
    res_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    flags_d = '0;
    case (s1_op_q)
      OP_ADD, OP_ADC: begin
        res_d = sum_ext[W-1:0];
        c_d   = sum_ext[W];
        v_d   = (s1_a_q[W-1] == s1_b_q[W-1]) && (res_d[W-1] != s1_a_q[W-1]);
      end
      OP_SUB, OP_SBC: begin
        res_d = dif_ext[W-1:0];
        c_d   = dif_ext[W];
        v_d   = (s1_a_q[W-1] != s1_b_q[W-1]) && (res_d[W-1] != s1_a_q[W-1]);
      end
      OP_MUL: res_d = mul_p;
      OP_AND: res_d = s1_a_q & s1_b_q;
      OP_OR:  res_d = s1_a_q | s1_b_q;
      OP_XOR: res_d = s1_a_q ^ s1_b_q;
      OP_NOT: res_d = ~s1_a_q;
      OP_SHR: begin res_d = {1'b0, s1_a_q[W-1:1]};         c_d = s1_a_q[0];   end
      OP_SHL: begin res_d = {s1_a_q[W-2:0], 1'b0};         c_d = s1_a_q[W-1]; end
      OP_ROR: begin res_d = {s1_a_q[0], s1_a_q[W-1:1]};    c_d = s1_a_q[0];   end
      OP_ROL: begin res_d = {s1_a_q[W-2:0], s1_a_q[W-1]};  c_d = s1_a_q[W-1]; end
      default: ;
    endcase
    err_d = !op_legal(s1_op_q, MUL_EN);
    if (err_d) begin
      res_d = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
    end else begin
      flags_d[FLG_Z] = (res_d == '0);
      flags_d[FLG_N] = res_d[W-1];
      flags_d[FLG_C] = c_d;
      flags_d[FLG_V] = v_d;
    end
    cf_d = (!err_d && op_sets_cf(s1_op_q)) ? c_d : cf_q;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= ctr;
      s1_a_q     <= a;
      s1_b_q     <= b;
    end else if (s1_move) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Result register holds its contents until the consumer takes them.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      o_q         <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      cf_q        <= 1'b0;
    end else if (s1_move) begin
      out_valid_q <= 1'b1;
      o_q         <= res_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      cf_q        <= cf_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule
